// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch win after MAX_WAIT data wins.
module mem_port_arbiter #(
   parameter int AW       = 64,
   parameter int DW       = 64,
   parameter int MAX_WAIT = 3    // legal range 1..15
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_valid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_cs,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   localparam logic [3:0] WMAX = 4'(MAX_WAIT);

   state_t          state_q,     state_d;
   logic [3:0]      wcnt_q,      wcnt_d;
   logic            mem_cs_q,    mem_cs_d;
   logic            mem_we_q,    mem_we_d;
   logic [AW-1:0]   mem_addr_q,  mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            if_gnt_q,    if_gnt_d;
   logic            dm_gnt_q,    dm_gnt_d;
   logic            if_valid_q,  if_valid_d;
   logic            dm_valid_q,  dm_valid_d;
   logic [DW-1:0]   if_rdata_q,  if_rdata_d;
   logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;

   always_comb begin
      // NOTE: every _d starts from its _q (pulses from 0) so no path can infer a latch.
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      mem_cs_d    = mem_cs_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         IDLE: begin
            // Fetch wins when alone, or when data has starved it MAX_WAIT times.
            if (if_req && (!dm_req || wcnt_q == WMAX)) begin
               state_d     = BUSY_IF;
               mem_cs_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               if_gnt_d    = 1'b1;
               wcnt_d      = '0;
            end else if (dm_req) begin
               state_d     = BUSY_DM;
               mem_cs_d    = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               dm_gnt_d    = 1'b1;
               if (if_req && wcnt_q < WMAX) wcnt_d = wcnt_q + 4'd1;
            end
         end
         BUSY_IF: begin
            if (mem_ready) begin
               state_d    = IDLE;
               mem_cs_d   = 1'b0;
               mem_we_d   = 1'b0;
               if_rdata_d = mem_rdata;
               if_valid_d = 1'b1;
            end
         end
         BUSY_DM: begin
            if (mem_ready) begin
               state_d    = IDLE;
               mem_cs_d   = 1'b0;
               mem_we_d   = 1'b0;
               dm_rdata_d = mem_we_q ? '0 : mem_rdata;
               dm_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values.
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_gnt    = if_gnt_q;
   assign dm_gnt    = dm_gnt_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

endmodule
